// File: rtl/det_pkg.sv
// Shared defaults, FSM encoding and index-width helper for the determinant
// matrix memory.
package det_pkg;

  localparam int DEF_MAX_N = 8;
  localparam int DEF_DW    = 20;
  localparam int DEF_RW    = 40;

  typedef enum logic [1:0] {
    ST_LOAD_N = 2'd0,
    ST_LOAD_M = 2'd1,
    ST_SERVE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Row/column index width; a 1x1 store still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/det_mem_array.sv
// MAX_N x MAX_N element store: one synchronous write port, one combinational
// read port. Contents are intentionally not reset.
module det_mem_array
  import det_pkg::*;
#(
  parameter int MAX_N = DEF_MAX_N,
  parameter int DW    = DEF_DW,
  localparam int IW   = idx_w(MAX_N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wr_row,
  input  logic [IW-1:0] wr_col,
  input  logic [DW-1:0] wr_data,
  input  logic [IW-1:0] rd_row,
  input  logic [IW-1:0] rd_col,
  output logic [DW-1:0] rd_data
);

  localparam logic [IW:0] LIM = (IW + 1)'(MAX_N);

  logic [DW-1:0] mem_q [MAX_N][MAX_N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_row][wr_col] <= wr_data;
    end
  end

  // Guard keeps non-power-of-two sizes from indexing past the array.
  always_comb begin
    rd_data = '0;
    if (({1'b0, rd_row} < LIM) && ({1'b0, rd_col} < LIM)) begin
      rd_data = mem_q[rd_row][rd_col];
    end
  end

endmodule

// File: rtl/det_mem.sv
// Matrix memory for a determinant engine: streams in N and an NxN matrix,
// serves zero-latency element reads, then captures the engine's result.
module det_mem
  import det_pkg::*;
#(
  parameter int MAX_N = DEF_MAX_N,
  parameter int DW    = DEF_DW,
  parameter int RW    = DEF_RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic [19:0]   i,
  input  logic [19:0]   j,
  input  logic          read,
  input  logic          write,
  output logic [DW-1:0] read_data,
  input  logic [RW-1:0] write_data,
  input  logic          finish,
  output logic [RW-1:0] result,
  output logic          result_valid,
  output logic          busy,
  output logic          cfg_err,
  output logic          addr_err,
  output logic [15:0]   rd_count,
  output logic [1:0]    dbg_state
);

  localparam int IW = idx_w(MAX_N);
  localparam int NW = $clog2(MAX_N + 1);
  localparam logic [DW-1:0] MAX_N_DW = DW'(MAX_N);

  // Load handshake: a word moves when ld_valid && ld_ready on a rising edge.
  // ld_ready is high exactly in LOAD_N and LOAD_M.
  state_e        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] row_q, row_d;
  logic [NW-1:0] col_q, col_d;
  logic [15:0]   rd_count_q, rd_count_d;
  logic          cfg_err_q, cfg_err_d;
  logic          addr_err_q, addr_err_d;
  logic [RW-1:0] result_q, result_d;
  logic          result_valid_q, result_valid_d;

  logic          ld_fire;
  logic          in_range;
  logic          elem_rd;
  logic          capture;
  logic [NW-1:0] n_last;
  logic          mem_we;
  logic [DW-1:0] mem_rd_data;

  assign ld_fire  = ld_valid && ld_ready;
  assign in_range = (i < 20'(n_q)) && (j < 20'(n_q));
  assign elem_rd  = read && !write;
  assign capture  = finish || (write && !read);
  assign n_last   = n_q - NW'(1);

  det_mem_array #(
    .MAX_N (MAX_N),
    .DW    (DW)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .wr_row  (row_q[IW-1:0]),
    .wr_col  (col_q[IW-1:0]),
    .wr_data (ld_data),
    .rd_row  (i[IW-1:0]),
    .rd_col  (j[IW-1:0]),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    row_d          = row_q;
    col_d          = col_q;
    rd_count_d     = rd_count_q;
    cfg_err_d      = cfg_err_q;
    addr_err_d     = addr_err_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    mem_we         = 1'b0;

    case (state_q)
      ST_LOAD_N: begin
        if (ld_fire) begin
          if ((ld_data != '0) && (ld_data <= MAX_N_DW)) begin
            n_d     = NW'(ld_data);
            row_d   = '0;
            col_d   = '0;
            state_d = ST_LOAD_M;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LOAD_M: begin
        if (ld_fire) begin
          mem_we = 1'b1;
          if (col_q == n_last) begin
            col_d = '0;
            if (row_q == n_last) begin
              state_d = ST_SERVE;
            end else begin
              row_d = row_q + NW'(1);
            end
          end else begin
            col_d = col_q + NW'(1);
          end
        end
      end
      ST_SERVE: begin
        if (read && !write) begin
          rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;
          if (!in_range) begin
            addr_err_d = 1'b1;
          end
        end
        if (capture) begin
          result_d       = write_data;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end
      end
      default: begin
      end
    endcase

    // Restart overrides anything that happened in the same cycle.
    if (clr) begin
      state_d        = ST_LOAD_N;
      n_d            = '0;
      row_d          = '0;
      col_d          = '0;
      rd_count_d     = '0;
      cfg_err_d      = 1'b0;
      addr_err_d     = 1'b0;
      result_d       = '0;
      result_valid_d = 1'b0;
      mem_we         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_LOAD_N;
      n_q            <= '0;
      row_q          <= '0;
      col_q          <= '0;
      rd_count_q     <= '0;
      cfg_err_q      <= 1'b0;
      addr_err_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      row_q          <= row_d;
      col_q          <= col_d;
      rd_count_q     <= rd_count_d;
      cfg_err_q      <= cfg_err_d;
      addr_err_q     <= addr_err_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // The engine samples read_data in the same cycle it drives i/j/strobes.
  always_comb begin
    read_data = '0;
    if ((state_q == ST_SERVE) && read) begin
      if (write) begin
        read_data = DW'(n_q);
      end else if (in_range) begin
        read_data = mem_rd_data;
      end
    end
  end

  assign ld_ready     = (state_q == ST_LOAD_N) || (state_q == ST_LOAD_M);
  assign busy         = (state_q == ST_SERVE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign cfg_err      = cfg_err_q;
  assign addr_err     = addr_err_q;
  assign rd_count     = rd_count_q;
  assign dbg_state    = state_q;

  // Unused when reading in-range elements only through the low index bits.
  logic unused_ok;
  assign unused_ok = &{1'b0, elem_rd};

endmodule

// File: tb/tb_det_mem.sv
// Bench for det_mem: a behavioural engine drives loads, reads and result
// writes; a monitor checks responses against queues of expected values.
module tb_det_mem;

  localparam int MAX_N = 8;
  localparam int DW    = 20;
  localparam int RW    = 40;

  logic          clk;
  logic          reset;
  logic          clr;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic [19:0]   ei;
  logic [19:0]   ej;
  logic          read;
  logic          write;
  logic [DW-1:0] read_data;
  logic [RW-1:0] write_data;
  logic          finish;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          busy;
  logic          cfg_err;
  logic          addr_err;
  logic [15:0]   rd_count;
  logic [1:0]    dbg_state;

  det_mem #(.MAX_N(MAX_N), .DW(DW), .RW(RW)) dut (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .i            (ei),
    .j            (ej),
    .read         (read),
    .write        (write),
    .read_data    (read_data),
    .write_data   (write_data),
    .finish       (finish),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .cfg_err      (cfg_err),
    .addr_err     (addr_err),
    .rd_count     (rd_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] rd_q  [$];
  logic [RW-1:0] res_q [$];

  int            n_mod;
  logic [DW-1:0] m_mod [8][8];
  bit            exp_aerr;
  logic [RW-1:0] exp_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Determinant by the permutation (Leibniz) formula, modulo 2^64.
  function automatic longint det_model();
    longint s, p;
    int     t_max, tmp, inv;
    int     perm [8];
    bit     ok;
    s = 0;
    t_max = 1;
    for (int k = 0; k < n_mod; k++) t_max *= n_mod;
    for (int t = 0; t < t_max; t++) begin
      tmp = t;
      for (int r = 0; r < n_mod; r++) begin
        perm[r] = tmp % n_mod;
        tmp = tmp / n_mod;
      end
      ok = 1'b1;
      inv = 0;
      for (int a = 0; a < n_mod; a++)
        for (int b = a + 1; b < n_mod; b++) begin
          if (perm[a] == perm[b]) ok = 1'b0;
          if (perm[a] > perm[b]) inv++;
        end
      if (ok) begin
        p = 1;
        for (int r = 0; r < n_mod; r++) p = p * longint'(signed'(m_mod[r][perm[r]]));
        s = (inv % 2 == 1) ? s - p : s + p;
      end
    end
    return s;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (read) begin
      if (rd_q.size() == 0) check("rd_unexpected", 64'(read_data), 64'hDEAD);
      else check("read_data", 64'(read_data), 64'(rd_q.pop_front()));
    end
    if (result_valid) begin
      if (res_q.size() == 0) check("result_valid_unexpected", 64'(result), 64'hDEAD);
      else check("result", 64'(result), 64'(res_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_word(input logic [DW-1:0] v);
    ld_valid = 1'b1;
    ld_data  = v;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic load_matrix();
    ld_word(DW'(n_mod));
    for (int k = 0; k < n_mod * n_mod; k++) ld_word(m_mod[k / n_mod][k % n_mod]);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_aerr = 1'b0;
  endtask

  task automatic engine(input int reps, input int n_rand, input bit use_finish);
    int     cnt, ii, jj;
    longint d;
    cnt = 0;
    read = 1'b1; write = 1'b1; ei = '0; ej = '0;
    rd_q.push_back(DW'(n_mod));
    tick();
    write = 1'b0;
    for (int r = 0; r < reps; r++)
      for (int a = 0; a < n_mod; a++)
        for (int b = 0; b < n_mod; b++) begin
          ei = 20'(a); ej = 20'(b);
          rd_q.push_back(m_mod[a][b]);
          tick();
          cnt++;
        end
    for (int q = 0; q < n_rand; q++) begin
      ii = $urandom_range(0, n_mod);
      jj = $urandom_range(0, n_mod);
      ei = 20'(ii); ej = 20'(jj);
      if (ii < n_mod && jj < n_mod) rd_q.push_back(m_mod[ii][jj]);
      else begin
        rd_q.push_back('0);
        exp_aerr = 1'b1;
      end
      tick();
      cnt++;
    end
    read = 1'b0;
    @(negedge clk);
    check("rd_count", 64'(rd_count), 64'(cnt));
    check("addr_err", 64'(addr_err), 64'(exp_aerr));
    check("busy_serve", 64'(busy), 64'd1);
    d = det_model();
    exp_res = RW'(d);
    if (use_finish) finish = 1'b1;
    else write = 1'b1;
    write_data = exp_res;
    res_q.push_back(exp_res);
    tick();
    write = 1'b1; finish = 1'b1; write_data = ~exp_res;
    @(negedge clk);
    check("busy_after_capture", 64'(busy), 64'd0);
    check("ld_ready_done", 64'(ld_ready), 64'd0);
    tick(); tick();
    write = 1'b0; finish = 1'b0;
    @(negedge clk);
    check("result_hold", 64'(result), 64'(exp_res));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; clr = 1'b0; ld_valid = 1'b0; ld_data = '0;
    ei = '0; ej = '0; read = 1'b0; write = 1'b0; write_data = '0; finish = 1'b0;
    exp_aerr = 1'b0; n_mod = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ld_ready", 64'(ld_ready), 64'd1);
    check("rst_read_data", 64'(read_data), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_addr_err", 64'(addr_err), 64'd0);
    check("rst_rd_count", 64'(rd_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    // A read outside SERVE is ignored.
    read = 1'b1; rd_q.push_back('0);
    tick();
    read = 1'b0;

    // 2x2: det(1 2; 3 4) = -2, each element read twice.
    n_mod = 2;
    m_mod[0][0] = 1; m_mod[0][1] = 2; m_mod[1][0] = 3; m_mod[1][1] = 4;
    load_matrix();
    @(negedge clk);
    check("busy_after_load", 64'(busy), 64'd1);
    check("ld_ready_serve", 64'(ld_ready), 64'd0);
    engine(2, 0, 1'b0);
    check("t1_result", 64'(result), 64'hFF_FFFF_FFFE);
    check("t1_rd_count", 64'(rd_count), 64'd8);
    tick();
    read = 1'b1; rd_q.push_back('0);
    tick();
    read = 1'b0;
    @(negedge clk);
    check("done_no_count", 64'(rd_count), 64'd8);

    // 3x3 diagonal, det = 24.
    do_clr();
    n_mod = 3;
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) m_mod[a][b] = '0;
    m_mod[0][0] = 2; m_mod[1][1] = 3; m_mod[2][2] = 4;
    load_matrix();
    engine(1, 0, 1'b0);
    check("t2_result", 64'(result), 64'd24);

    // Bad dimensions, then a 1x1 of -1.
    do_clr();
    ld_word(0);
    @(negedge clk);
    check("cfg_err_zero", 64'(cfg_err), 64'd1);
    check("cfg_stay_load_n", 64'(dbg_state), 64'd0);
    ld_word(9);
    @(negedge clk);
    check("cfg_err_nine", 64'(cfg_err), 64'd1);
    check("cfg_ld_ready", 64'(ld_ready), 64'd1);
    n_mod = 1; m_mod[0][0] = 20'hFFFFF;
    load_matrix();
    engine(1, 0, 1'b1);
    check("t3_result", 64'(result), 64'hFF_FFFF_FFFF);
    check("t3_cfg_sticky", 64'(cfg_err), 64'd1);

    // Out-of-range read, then clr colliding with a result write.
    do_clr();
    @(negedge clk);
    check("clr_cfg_err", 64'(cfg_err), 64'd0);
    check("clr_result", 64'(result), 64'd0);
    n_mod = 2;
    for (int a = 0; a < 2; a++) for (int b = 0; b < 2; b++) m_mod[a][b] = DW'($urandom);
    load_matrix();
    tick();
    read = 1'b1; ei = 20'd2; ej = 20'd0; rd_q.push_back('0);
    tick();
    read = 1'b0;
    @(negedge clk);
    check("oob_addr_err", 64'(addr_err), 64'd1);
    check("oob_rd_count", 64'(rd_count), 64'd1);
    tick();
    write = 1'b1; write_data = 40'h12_3456_789A; clr = 1'b1;
    tick();
    write = 1'b0; clr = 1'b0; exp_aerr = 1'b0;
    @(negedge clk);
    check("clrw_result_valid", 64'(result_valid), 64'd0);
    check("clrw_result", 64'(result), 64'd0);
    check("clrw_state", 64'(dbg_state), 64'd0);
    check("clrw_rd_count", 64'(rd_count), 64'd0);
    check("clrw_addr_err", 64'(addr_err), 64'd0);
    tick();
    // clr also beats a load word.
    ld_valid = 1'b1; ld_data = 20'd3; clr = 1'b1;
    tick();
    ld_valid = 1'b0; clr = 1'b0;
    @(negedge clk);
    check("clrld_state", 64'(dbg_state), 64'd0);

    // Reset in the middle of LOAD_M, then a full reload.
    tick();
    ld_word(3); ld_word(5); ld_word(6);
    reset = 1'b0;
    @(negedge clk);
    check("rstm_ld_ready", 64'(ld_ready), 64'd1);
    check("rstm_state", 64'(dbg_state), 64'd0);
    tick();
    reset = 1'b1;
    exp_aerr = 1'b0;
    tick();
    n_mod = 2;
    m_mod[0][0] = 7; m_mod[0][1] = 1; m_mod[1][0] = 2; m_mod[1][1] = 5;
    load_matrix();
    engine(1, 0, 1'b0);
    check("t5_result", 64'(result), 64'd33);

    // Randomized matrices with random extra reads.
    for (int it = 0; it < 8; it++) begin
      do_clr();
      n_mod = $urandom_range(1, 4);
      for (int a = 0; a < n_mod; a++)
        for (int b = 0; b < n_mod; b++) m_mod[a][b] = DW'($urandom);
      load_matrix();
      engine(1, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("res_q_drained", 64'(res_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
